// File: rtl/mat_result_checker.sv
// Sweeps result (C) and golden memories in lockstep and counts word mismatches.
// Latency: done pulses DEPTH+2 cycles after start is sampled; results held until next start.
// No backpressure: one read per cycle, memories must return data exactly one cycle after rd_en.
module mat_result_checker #(
  parameter int DATA_W = 22,
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4096
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] c_rdata,
  input  logic [DATA_W-1:0] g_rdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   err_cnt,
  output logic              first_err_vld,
  output logic [ADDR_W-1:0] first_err_addr
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t              r_state;
  logic                r_rd_en;
  logic [ADDR_W-1:0]   r_rd_addr;
  logic                r_busy;
  logic                r_done;
  logic                r_cmp_vld;
  logic [ADDR_W-1:0]   r_cmp_addr;
  logic [ADDR_W:0]     r_err_cnt;
  logic                r_first_err_vld;
  logic [ADDR_W-1:0]   r_first_err_addr;

  logic                w_accept;
  logic                w_mismatch;

  // start only counts when the sweep engine is idle; DONE-cycle starts fall through
  assign w_accept   = (r_state == IDLE) && start;
  assign w_mismatch = r_cmp_vld && (c_rdata != g_rdata);

  // Sweep sequencer: issues addresses 0..DEPTH-1, then one drain cycle, then done
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state   <= IDLE;
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state   <= READ;
            r_rd_en   <= 1'b1;
            r_rd_addr <= '0;
            r_busy    <= 1'b1;
          end
        end
        READ: begin
          if (r_rd_addr == LAST_ADDR) begin
            r_rd_en <= 1'b0;
            r_state <= DRAIN;
          end else begin
            r_rd_addr <= r_rd_addr + ADDR_W'(1);
          end
        end
        DRAIN: begin
          // last word's data is compared during this cycle
          r_state <= DONE;
          r_done  <= 1'b1;
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_rd_en <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // Tag returning read data with the address that produced it
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_cmp_vld  <= 1'b0;
      r_cmp_addr <= '0;
    end else begin
      r_cmp_vld  <= r_rd_en;
      r_cmp_addr <= r_rd_addr;
    end
  end

  // Mismatch accounting: cleared on an accepted start, first error address latched once
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_err_cnt        <= '0;
      r_first_err_vld  <= 1'b0;
      r_first_err_addr <= '0;
    end else if (w_accept) begin
      r_err_cnt        <= '0;
      r_first_err_vld  <= 1'b0;
      r_first_err_addr <= '0;
    end else if (w_mismatch) begin
      r_err_cnt <= r_err_cnt + (ADDR_W+1)'(1);
      if (!r_first_err_vld) begin
        r_first_err_vld  <= 1'b1;
        r_first_err_addr <= r_cmp_addr;
      end
    end
  end

  assign rd_en          = r_rd_en;
  assign rd_addr        = r_rd_addr;
  assign busy           = r_busy;
  assign done           = r_done;
  assign err_cnt        = r_err_cnt;
  assign first_err_vld  = r_first_err_vld;
  assign first_err_addr = r_first_err_addr;

endmodule

// File: doc/mat_result_checker.md
# mat_result_checker

- Self-checking readout stage downstream of the matrix-multiply top controller.
- On `start`, sweeps the result memory (C) from address 0 to DEPTH-1 and reads the golden-reference memory at the same address.
- Compares each word pair and reports the mismatch count and first mismatching address, then pulses `done`.
- Turns the end-of-run C-matrix comparison into synthesizable hardware; `start` is normally tied to the multiplier's `done`.

## Interface

Parameters:
- DATA_W, 22, width of one C-matrix element (and golden element)
- ADDR_W, 12, memory address width
- DEPTH, 4096, number of words checked; must be ≤ 2^ADDR_W

Ports:
- clk  input  1  system clock; all logic on rising edge
- rstn  input  1  reset; synchronous, active-low
- start  input  1  one-cycle request to begin a sweep; honoured only in IDLE
- rd_en  output  1  read strobe to both memories
- rd_addr  output  ADDR_W  shared read address for C and golden memories
- c_rdata  input  DATA_W  C memory read data, valid exactly one cycle after `rd_en`
- g_rdata  input  DATA_W  golden memory read data, same latency as `c_rdata`
- busy  output  1  high from the cycle after `start` is accepted until the `done` cycle inclusive
- done  output  1  one-cycle pulse when the sweep is complete
- err_cnt  output  ADDR_W+1  number of mismatching words in the last/current sweep
- first_err_vld  output  1  at least one mismatch seen in the current sweep
- first_err_addr  output  ADDR_W  address of the first mismatch; 0 when `first_err_vld`=0

## Operation

- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE -> READ when `start`=1.
  - On acceptance: clear `err_cnt`, `first_err_vld` and `first_err_addr`; load address counter with 0.
- READ:
  - `rd_en`=1 and `rd_addr`=counter.
  - Counter increments each cycle.
  - After issuing address DEPTH-1, go to DRAIN.
- DRAIN (1 cycle):
  - `rd_en`=0.
  - Compare the last returned word, then go to DONE.
- DONE (1 cycle):
  - `done`=1, then go to IDLE.
- Compare pipeline:
  - A one-cycle delayed copy of `rd_en` (`cmp_vld`) and of `rd_addr` (`cmp_addr`) tags returning data.
  - When `cmp_vld`=1 and `c_rdata`≠`g_rdata`, `err_cnt` increments at that clock edge.
  - If `first_err_vld`=0 at that edge, latch `first_err_addr`=`cmp_addr` and set `first_err_vld`.
- Compare is a full DATA_W-bit equality; no masking or tolerance.
- `err_cnt` width ADDR_W+1 holds up to DEPTH (4096) without saturation or wrap.
- Results hold after DONE until the next accepted `start`.
- `start` while not in IDLE is ignored, with no restart and no effect on counters.
- `start` in the same cycle as DONE is ignored; it is accepted only in IDLE.

## Timing

- Reset (`rstn`=0 at a clock edge):
  - State IDLE.
  - `rd_en`, `busy`, `done`, `first_err_vld` = 0.
  - `rd_addr`, `err_cnt`, `first_err_addr` = 0.
  - `cmp_vld` = 0.
- Numbering cycles from the one where `start` is sampled as cycle 0:
  - `rd_en`=1 in cycles 1..DEPTH, with `rd_addr`=cycle-1.
  - Data for address k is compared in cycle k+2.
  - DRAIN is cycle DEPTH+1.
  - `done`=1 in cycle DEPTH+2 (4098 for defaults), with final `err_cnt` and `first_err_*` valid in that same cycle.
- `busy` rises in cycle 1 and falls after cycle DEPTH+2. A new `start` is accepted at the earliest in cycle DEPTH+3.
- Reset mid-sweep returns to IDLE the next cycle with reset values.
  - No `done` pulse.
  - In-flight read data is discarded (`cmp_vld` cleared).
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan

- Reset/idle: hold `rstn`=0 for 2 cycles, then release with no `start` -> all outputs 0 for 20 cycles; `rd_en` never asserts.
- Clean sweep: both memories loaded with the identical C vector file; pulse `start` -> `rd_addr` 0..4095 in consecutive cycles, `done` exactly at cycle 4098, `err_cnt`=0, `first_err_vld`=0.
- Injected errors: corrupt C words at addresses 7, 2048 and 4095 (flip bit 21) -> `err_cnt`=3, `first_err_vld`=1, `first_err_addr`=7. Corrupting only address 4095 -> `err_cnt`=1, `first_err_addr`=4095; this checks the DRAIN compare.
- All-mismatch: golden = ~C for every word -> `err_cnt`=4096 (13'h1000), `first_err_addr`=0.
- Start while busy: pulse `start` again at cycles 100 and 4098 -> no restart, `done` once at 4098, results unchanged. A `start` at cycle 4099 begins a new sweep and clears `err_cnt` in cycle 4100.
- Mid-sweep reset: assert `rstn`=0 at cycle 1000 for 1 cycle -> next cycle all outputs at reset values, no `done`. A subsequent `start` performs a full, correct sweep.
